// File: rtl/instr_inv_queue_pkg.sv
// Shared configuration for the instruction-coherency invalidation queue.
// Holds default sizing, the line-address width helper and the line type.
package instr_inv_queue_pkg;

  localparam int unsigned INSTR_INV_QUEUE_DEPTH = 4;
  localparam int unsigned NUM_INV_SOURCES       = 2;
  localparam int unsigned INV_ADDR_W            = 32;
  localparam int unsigned INV_LINE_W            = 4;

  // Line address drops the word offset (2 bits) and the word-in-line index.
  function automatic int unsigned line_addr_w(int unsigned addr_w, int unsigned line_w);
    return addr_w - 2 - $clog2(line_w);
  endfunction

  localparam int unsigned INV_LINE_ADDR_W = line_addr_w(INV_ADDR_W, INV_LINE_W);

  typedef logic [INV_LINE_ADDR_W-1:0] inv_line_t;

endpackage

// File: rtl/inv_source_compactor.sv
// Coalesces same-line invalidation sources and packs the survivors into
// contiguous write slots in ascending source order. Purely combinational.
module inv_source_compactor import instr_inv_queue_pkg::*; #(
  parameter int unsigned NUM_SOURCES = NUM_INV_SOURCES,
  parameter int unsigned ADDR_W      = INV_ADDR_W,
  parameter int unsigned LINE_W      = INV_LINE_W,
  localparam int unsigned LineAddrW  = line_addr_w(ADDR_W, LINE_W),
  localparam int unsigned CntW       = $clog2(NUM_SOURCES + 1)
) (
  input  logic [NUM_SOURCES-1:0]           src_valid,
  input  logic [NUM_SOURCES*ADDR_W-1:0]    src_addr,
  input  logic                             last_valid,
  input  logic [LineAddrW-1:0]             last_line,
  output logic [CntW-1:0]                  push_count,
  output logic [NUM_SOURCES*LineAddrW-1:0] push_lines
);

  localparam int unsigned Off = ADDR_W - LineAddrW;

  logic [LineAddrW-1:0]     line [NUM_SOURCES];
  logic [NUM_SOURCES-1:0]   keep;
  logic [NUM_SOURCES*Off-1:0] unused_offset_bits;

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    assign line[i] = src_addr[i*ADDR_W+Off +: LineAddrW];
    assign unused_offset_bits[i*Off +: Off] = src_addr[i*ADDR_W +: Off];
  end

  // A source survives unless a lower-index source or the newest queued entry
  // already covers its line.
  always_comb begin
    keep = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      keep[i] = src_valid[i] && !(last_valid && (line[i] == last_line));
      for (int j = 0; j < i; j++) begin
        if (src_valid[j] && (line[j] == line[i])) begin
          keep[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    push_count = '0;
    push_lines = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (keep[i]) begin
        push_lines[int'(push_count)*LineAddrW +: LineAddrW] = line[i];
        push_count = push_count + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/instr_inv_queue.sv
// Invalidation queue between committed stores and the icache/branch predictor.
// Multi-source enqueue with coalescing, forked head handshake, flush-all on overflow.
module instr_inv_queue import instr_inv_queue_pkg::*; #(
  parameter int unsigned DEPTH       = INSTR_INV_QUEUE_DEPTH,
  parameter int unsigned NUM_SOURCES = NUM_INV_SOURCES,
  parameter int unsigned ADDR_W      = INV_ADDR_W,
  parameter int unsigned LINE_W      = INV_LINE_W,
  localparam int unsigned LineAddrW  = line_addr_w(ADDR_W, LINE_W)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SOURCES-1:0]        src_valid,
  input  logic [NUM_SOURCES*ADDR_W-1:0] src_addr,
  output logic [LineAddrW-1:0]          inv_line,
  output logic                          inv_all,
  output logic                          icache_inv_valid,
  input  logic                          icache_inv_ack,
  output logic                          bp_inv_valid,
  input  logic                          bp_inv_ack,
  output logic                          busy,
  output logic [15:0]                   overflow_count
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned PushW = $clog2(NUM_SOURCES + 1);
  localparam int unsigned SumW  = CntW + PushW + 1;

  logic [LineAddrW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, last_ptr;
  logic [CntW-1:0]      count_q, count_d;
  logic                 ic_done_q, ic_done_d, bp_done_q, bp_done_d;
  logic                 pending_all_q, pending_all_d;
  logic [15:0]          ovf_cnt_q, ovf_cnt_d;

  logic                           fifo_nonempty, head_valid, pop, pop_fifo;
  logic                           src_block, last_is_head, last_valid, overflow, do_write;
  logic [NUM_SOURCES-1:0]         gated_valid;
  logic [PushW-1:0]               push_count;
  logic [NUM_SOURCES*LineAddrW-1:0] push_lines;
  logic [SumW-1:0]                next_count;
  logic [PtrW-1:0]                wr_idx [NUM_SOURCES];

  assign fifo_nonempty = count_q != '0;
  assign head_valid    = pending_all_q | fifo_nonempty;
  assign pop           = head_valid & (icache_inv_ack | ic_done_q) & (bp_inv_ack | bp_done_q);
  assign pop_fifo      = pop & ~pending_all_q;

  // Until someone has taken the flush-all, new stores are already covered by it.
  assign src_block   = pending_all_q & ~ic_done_q & ~bp_done_q;
  assign gated_valid = src_valid & ~{NUM_SOURCES{src_block}};

  assign last_ptr     = wr_ptr_q - PtrW'(1);
  assign last_is_head = count_q == CntW'(1);
  // The newest entry stops absorbing repeats once a consumer has seen it.
  assign last_valid   = fifo_nonempty &
                        ~(last_is_head & ~pending_all_q & (ic_done_q | bp_done_q | pop));

  inv_source_compactor #(
    .NUM_SOURCES (NUM_SOURCES),
    .ADDR_W      (ADDR_W),
    .LINE_W      (LINE_W)
  ) u_compactor (
    .src_valid  (gated_valid),
    .src_addr   (src_addr),
    .last_valid (last_valid),
    .last_line  (mem_q[last_ptr]),
    .push_count (push_count),
    .push_lines (push_lines)
  );

  assign next_count = SumW'(count_q) + SumW'(push_count) - SumW'(pop_fifo);
  assign overflow   = next_count > SumW'(DEPTH);

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_idx
    assign wr_idx[i] = wr_ptr_q + PtrW'(i);
  end

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    ic_done_d     = ic_done_q;
    bp_done_d     = bp_done_q;
    pending_all_d = pending_all_q;
    ovf_cnt_d     = ovf_cnt_q;
    do_write      = 1'b0;

    if (pop) begin
      ic_done_d = 1'b0;
      bp_done_d = 1'b0;
      if (pending_all_q) begin
        pending_all_d = 1'b0;
      end else begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
    end else begin
      if (icache_inv_ack && head_valid) ic_done_d = 1'b1;
      if (bp_inv_ack && head_valid)     bp_done_d = 1'b1;
    end

    if (overflow) begin
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      ic_done_d     = 1'b0;
      bp_done_d     = 1'b0;
      pending_all_d = 1'b1;
      ovf_cnt_d     = (ovf_cnt_q == 16'hFFFF) ? ovf_cnt_q : ovf_cnt_q + 16'd1;
    end else begin
      count_d  = next_count[CntW-1:0];
      wr_ptr_d = wr_ptr_q + PtrW'(push_count);
      do_write = push_count != '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      ic_done_q     <= 1'b0;
      bp_done_q     <= 1'b0;
      pending_all_q <= 1'b0;
      ovf_cnt_q     <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      ic_done_q     <= ic_done_d;
      bp_done_q     <= bp_done_d;
      pending_all_q <= pending_all_d;
      ovf_cnt_q     <= ovf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (i < int'(push_count)) begin
          mem_q[wr_idx[i]] <= push_lines[i*LineAddrW +: LineAddrW];
        end
      end
    end
  end

  assign inv_all          = pending_all_q;
  assign icache_inv_valid = head_valid & ~ic_done_q;
  assign bp_inv_valid     = head_valid & ~bp_done_q;
  assign busy             = head_valid;
  assign overflow_count   = ovf_cnt_q;
  assign inv_line         = (fifo_nonempty && !pending_all_q) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_instr_inv_queue.sv
// Bench for instr_inv_queue: directed vector table, then random traffic
// compared every cycle against a queue-level reference model.
module tb_instr_inv_queue;
  import instr_inv_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_valid;
  logic [63:0] src_addr;
  logic [27:0] inv_line;
  logic        inv_all, icache_inv_valid, icache_inv_ack, bp_inv_valid, bp_inv_ack, busy;
  logic [15:0] overflow_count;

  always #5 clk = ~clk;

  instr_inv_queue #(
    .DEPTH       (4),
    .NUM_SOURCES (2),
    .ADDR_W      (32),
    .LINE_W      (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .src_valid        (src_valid),
    .src_addr         (src_addr),
    .inv_line         (inv_line),
    .inv_all          (inv_all),
    .icache_inv_valid (icache_inv_valid),
    .icache_inv_ack   (icache_inv_ack),
    .bp_inv_valid     (bp_inv_valid),
    .bp_inv_ack       (bp_inv_ack),
    .busy             (busy),
    .overflow_count   (overflow_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of pending lines plus flush-all state.
  inv_line_t   mq[$];
  bit          m_pend, m_icd, m_bpd;
  int unsigned m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit [1:0] v, input logic [31:0] a0,
                            input logic [31:0] a1, input bit ica, input bit bpa);
    inv_line_t ln[2];
    inv_line_t acc[$];
    bit hv, pop, block, lastok, dup;
    int newsize;
    if (r) begin
      mq.delete();
      m_pend = 0; m_icd = 0; m_bpd = 0; m_ovf = 0;
      return;
    end
    ln[0] = a0[31:4];
    ln[1] = a1[31:4];
    hv     = m_pend || (mq.size() != 0);
    pop    = hv && (ica || m_icd) && (bpa || m_bpd);
    block  = m_pend && !m_icd && !m_bpd;
    lastok = (mq.size() != 0) && !((mq.size() == 1) && !m_pend && (m_icd || m_bpd || pop));
    for (int i = 0; i < 2; i++) begin
      if (v[i] && !block) begin
        dup = 0;
        for (int j = 0; j < i; j++) if (v[j] && ln[j] == ln[i]) dup = 1;
        if (lastok && ln[i] == mq[$]) dup = 1;
        if (!dup) acc.push_back(ln[i]);
      end
    end
    newsize = mq.size() + acc.size() - ((pop && !m_pend) ? 1 : 0);
    if (newsize > 4) begin
      mq.delete();
      m_pend = 1; m_icd = 0; m_bpd = 0;
      if (m_ovf < 65535) m_ovf++;
    end else begin
      if (pop) begin
        if (m_pend) m_pend = 0;
        else void'(mq.pop_front());
        m_icd = 0; m_bpd = 0;
      end else begin
        if (ica && hv) m_icd = 1;
        if (bpa && hv) m_bpd = 1;
      end
      foreach (acc[k]) mq.push_back(acc[k]);
    end
  endtask

  task automatic check_model();
    bit hv;
    logic [31:0] exp_line;
    hv = m_pend || (mq.size() != 0);
    exp_line = (!m_pend && mq.size() != 0) ? 32'(mq[0]) : 32'h0;
    check("model icache_inv_valid", 32'(icache_inv_valid), 32'(hv && !m_icd));
    check("model bp_inv_valid", 32'(bp_inv_valid), 32'(hv && !m_bpd));
    check("model inv_all", 32'(inv_all), 32'(m_pend));
    check("model inv_line", 32'(inv_line), exp_line);
    check("model busy", 32'(busy), 32'(hv));
    check("model overflow_count", 32'(overflow_count), m_ovf);
  endtask

  task automatic cycle(input bit r, input bit [1:0] v, input logic [31:0] a0,
                       input logic [31:0] a1, input bit ica, input bit bpa);
    rst = r; src_valid = v; src_addr = {a1, a0};
    icache_inv_ack = ica; bp_inv_ack = bpa;
    @(posedge clk);
    model_step(r, v, a0, a1, ica, bpa);
    #1;
    check_model();
  endtask

  typedef struct {
    bit          r;
    bit [1:0]    v;
    logic [31:0] a0, a1;
    bit          ica, bpa;
    bit          icv, bpv, all;
    logic [27:0] line;
    bit          bsy;
    logic [15:0] ovf;
  } vec_t;

  function automatic vec_t mk(bit r, bit [1:0] v, logic [31:0] a0, logic [31:0] a1, bit ica,
                              bit bpa, bit icv, bit bpv, bit all, logic [27:0] line, bit bsy,
                              logic [15:0] ovf);
    vec_t t;
    t.r = r; t.v = v; t.a0 = a0; t.a1 = a1; t.ica = ica; t.bpa = bpa;
    t.icv = icv; t.bpv = bpv; t.all = all; t.line = line; t.bsy = bsy; t.ovf = ovf;
    return t;
  endfunction

  vec_t vecs[$];

  initial begin
    int ack_pct;
    bit [1:0] rv;
    logic [31:0] ra0, ra1;

    rst = 1'b1; src_valid = '0; src_addr = '0; icache_inv_ack = 1'b0; bp_inv_ack = 1'b0;

    // Expected outputs are those visible just after the row's clock edge.
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0,  0, 0, 0, 28'h0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 32'h80000010, 0, 0, 0,  1, 1, 0, 28'h8000001, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0,  1, 1, 0, 28'h8000001, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 0,  0, 1, 0, 28'h8000001, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0,  0, 1, 0, 28'h8000001, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 1,  0, 0, 0, 28'h0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 32'h80000020, 32'h8000002C, 0, 0,  1, 1, 0, 28'h8000002, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 1,  0, 0, 0, 28'h0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 32'h80000020, 32'h80000030, 0, 0,  1, 1, 0, 28'h8000002, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 1,  1, 1, 0, 28'h8000003, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 1,  0, 0, 0, 28'h0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 32'h80000040, 32'h80000050, 0, 0,  1, 1, 0, 28'h8000004, 1, 0));
    vecs.push_back(mk(0, 2'b11, 32'h80000060, 32'h80000070, 0, 0,  1, 1, 0, 28'h8000004, 1, 0));
    vecs.push_back(mk(0, 2'b01, 32'h80000100, 0, 0, 0,  1, 1, 1, 28'h0, 1, 1));
    vecs.push_back(mk(0, 2'b01, 32'h80000200, 0, 0, 0,  1, 1, 1, 28'h0, 1, 1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 0,  0, 1, 1, 28'h0, 1, 1));
    vecs.push_back(mk(0, 2'b01, 32'h80000300, 0, 0, 0,  0, 1, 1, 28'h0, 1, 1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 1,  1, 1, 0, 28'h8000030, 1, 1));
    vecs.push_back(mk(0, 2'b11, 32'h80000400, 32'h80000500, 0, 0,  1, 1, 0, 28'h8000030, 1, 1));
    vecs.push_back(mk(0, 2'b01, 32'h80000600, 0, 0, 0,  1, 1, 0, 28'h8000030, 1, 1));
    vecs.push_back(mk(0, 2'b01, 32'h80000700, 0, 1, 1,  1, 1, 0, 28'h8000040, 1, 1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 1,  1, 1, 0, 28'h8000050, 1, 1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 0,  0, 1, 0, 28'h8000050, 1, 1));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0,  0, 0, 0, 28'h0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 32'h80000800, 0, 0, 0,  1, 1, 0, 28'h8000080, 1, 0));
    vecs.push_back(mk(0, 2'b01, 32'h80000804, 0, 0, 0,  1, 1, 0, 28'h8000080, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 1,  0, 0, 0, 28'h0, 0, 0));
    vecs.push_back(mk(0, 2'b01, 32'h80000900, 0, 0, 0,  1, 1, 0, 28'h8000090, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 0,  0, 1, 0, 28'h8000090, 1, 0));
    vecs.push_back(mk(0, 2'b01, 32'h80000904, 0, 0, 0,  0, 1, 0, 28'h8000090, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 1,  1, 1, 0, 28'h8000090, 1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 1,  0, 0, 0, 28'h0, 0, 0));

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].v, vecs[i].a0, vecs[i].a1, vecs[i].ica, vecs[i].bpa);
      check($sformatf("vec%0d icache_inv_valid", i), 32'(icache_inv_valid), 32'(vecs[i].icv));
      check($sformatf("vec%0d bp_inv_valid", i), 32'(bp_inv_valid), 32'(vecs[i].bpv));
      check($sformatf("vec%0d inv_all", i), 32'(inv_all), 32'(vecs[i].all));
      check($sformatf("vec%0d inv_line", i), 32'(inv_line), 32'(vecs[i].line));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
      check($sformatf("vec%0d overflow_count", i), 32'(overflow_count), 32'(vecs[i].ovf));
    end

    // Random traffic over a small line pool, alternating light and heavy ack rates.
    for (int n = 0; n < 3000; n++) begin
      ack_pct = ((n / 200) % 2 == 1) ? 75 : 15;
      rv  = 2'($urandom);
      ra0 = 32'h80000000 | (32'($urandom_range(0, 5)) << 4) | 32'($urandom_range(0, 15));
      ra1 = 32'h80000000 | (32'($urandom_range(0, 5)) << 4) | 32'($urandom_range(0, 15));
      cycle($urandom_range(0, 149) == 0, rv, ra0, ra1,
            $urandom_range(0, 99) < ack_pct, $urandom_range(0, 99) < ack_pct);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_inv_queue.md
Name: instr_inv_queue

Overview:
Buffers instruction-coherency invalidations raised by committed stores and forwards them to the icache and the branch predictor. It generalises the single-input, fixed-depth invalidation queue to NUM_SOURCES simultaneous inputs and a power-of-2 depth. It also adds same-line coalescing and an overflow fallback to a flush-all request. It is instantiated only when INSTRUCTION_COHERENCY=1, in front of the icache and branch predictor.

Parameters:
DEPTH, 4, queue entries; power of 2, >=2 (sourced from INSTR_INV_QUEUE_DEPTH)
NUM_SOURCES, 2, invalidation inputs per cycle, 1..4
ADDR_W, 32, byte address width
LINE_W, 4, cache line size in words; power of 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
src_valid  in  NUM_SOURCES  per-source invalidation request; no backpressure
src_addr  in  NUM_SOURCES*ADDR_W  byte addresses, source i at [i*ADDR_W +: ADDR_W]
inv_line  out  LINE_ADDR_W  head line address, LINE_ADDR_W = ADDR_W-2-$clog2(LINE_W)
inv_all  out  1  head is a flush-all request; inv_line don't-care
icache_inv_valid  out  1  head presented to icache
icache_inv_ack  in  1  icache consumed head
bp_inv_valid  out  1  head presented to branch predictor
bp_inv_ack  in  1  branch predictor consumed head
busy  out  1  queue non-empty or flush-all outstanding (fence.i waits on low)
overflow_count  out  16  saturating count of overflow events

Behaviour:
- Reset (synchronous, active-high): pointers=0, count=0, done flags=0, pending_all=0. All outputs 0 in the cycle after rst is sampled high. Reset mid-handshake discards all entries.
- Line address = src_addr[ADDR_W-1 : 2+$clog2(LINE_W)].
- Enqueue order per cycle is ascending source index.
- Coalescing:
  - A source is dropped if its line equals the line of a lower-index valid source in the same cycle.
  - A source is also dropped if its line equals the last-written entry, and that entry is not the head with a done flag set and is not popping this cycle.
- Storage is a registered FIFO with no bypass. An entry enqueued at cycle t is presented at t+1 if the queue was empty.
- Fork handshake:
  - icache_inv_valid = head_valid & ~ic_done.
  - bp_inv_valid = head_valid & ~bp_done.
  - An ack sets the matching done flag. An ack while the flag is already set is ignored.
  - Pop when (icache_inv_ack|ic_done) & (bp_inv_ack|bp_done). The pop clears both flags in the same edge.
  - The head stays stable until popped.
- Occupancy: next_count = count + accepted - pop, with width $clog2(DEPTH)+1. Pointers are $clog2(DEPTH) bits and wrap naturally. Pop and push in the same cycle at full is legal and is not an overflow.
- Overflow: if next_count would exceed DEPTH:
  - all queued entries and all of this cycle's sources are discarded;
  - pointers and count reset, done flags clear;
  - pending_all is set and overflow_count increments (saturating at 16'hFFFF).
- While pending_all=1:
  - the head presented is inv_all=1 with the same fork handshake;
  - new sources are dropped only while neither consumer has acked the flush-all;
  - once either consumer has acked, sources enqueue normally behind it;
  - pending_all clears when both have acked.
- busy = (count!=0) | pending_all.

Decomposition:
- cva5_config gets the following additions:
  - NUM_INV_SOURCES localparam;
  - inv_line_t typedef derived from ADDR_W and LINE_W;
  - derived-parameter helper giving LINE_ADDR_W.
- INSTR_INV_QUEUE_DEPTH feeds DEPTH.
- One sub-module, inv_source_compactor, is natural. It is combinational: it coalesces the sources and packs them into contiguous write slots (count plus packed lines).
- The FIFO and the handshake state stay in instr_inv_queue.

Test Plan:
All scenarios use DEPTH=4, NUM_SOURCES=2, LINE_W=4.
1. Single push: src0 0x80000010 at t → t+1 both valids=1, inv_line 0x8000001. icache_ack at t+2: icache_inv_valid=0 at t+3, bp_inv_valid stays 1. bp_ack at t+4 → busy=0 at t+5.
2. Same-cycle coalescing: src0 0x80000020 and src1 0x8000002C in one cycle → exactly one entry (0x8000002). Different lines 0x80000020 and 0x80000030 → two entries, presented 0x8000002 then 0x8000003.
3. Overflow: 4 distinct lines queued with no acks, then push 0x80000100 → next cycle inv_all=1, both valids=1, overflow_count=1, queue empty behind the flush-all.
4. Flush-all gating: with pending_all and no acks, push 0x80000200 → dropped. After icache_ack, push 0x80000300 → queued. After bp_ack, head becomes line 0x8000030.
5. Full with simultaneous pop and push: 4 entries, both acks plus one new line in the same cycle → count stays 4, overflow_count unchanged.
6. Reset mid-operation: 3 entries with ic_done set, rst=1 for one cycle → all valids=0, busy=0, overflow_count=0 after reset.
